// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake bundle between stream sources, stream_mux_rr and its sink
// Ports carried:
//   in_data   CHANNELS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel word present
//   in_ready  CHANNELS        per-channel accept (from the mux)
//   mode      1               0 = fixed select by s, 1 = round-robin
//   s         SEL_W           fixed-mode channel select
//   out_data  WIDTH           registered winning word
//   out_chan  SEL_W           channel that supplied out_data
//   out_valid 1               output register holds a word
//   out_ready 1               downstream accept
interface stream_mux_rr_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          s;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  // Mux side
  modport slave (
    input  in_data, in_valid, mode, s, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  // Source/sink side
  modport master (
    output in_data, in_valid, mode, s, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux with fixed or round-robin selection
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    stream_mux_rr_if.slave: in_data/in_valid/in_ready per channel,
//          mode/s selection controls, out_data/out_chan/out_valid/out_ready output
module stream_mux_rr #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_mux_rr_if.slave   bus
);

  logic [WIDTH-1:0]    out_data_q;
  logic [SEL_W-1:0]    out_chan_q;
  logic                out_valid_q;
  logic [SEL_W-1:0]    ptr;

  logic                load;
  logic                grant_vld;
  logic [SEL_W-1:0]    grant;
  logic [WIDTH-1:0]    win_data;
  logic [CHANNELS-1:0] ready_vec;
  logic                xfer;

  // The output register can take a word when empty or being drained this cycle.
  assign load = !out_valid_q || bus.out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (!bus.mode) begin
      // Out-of-range s simply matches no channel.
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.s == SEL_W'(i) && bus.in_valid[i]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(i);
        end
      end
    end else begin
      // Offset k from ptr; scanning k downwards lets the smallest offset win.
      // Channel i sits at offset k when ptr+k == i, or ptr+k == i+CHANNELS after wrap.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (bus.in_valid[i] &&
              ((int'(ptr) + k == i) || (int'(ptr) + k == i + CHANNELS))) begin
            grant_vld = 1'b1;
            grant     = SEL_W'(i);
          end
        end
      end
    end
  end

  // Word of the granted channel; only the registered copy ever reaches an output.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) begin
        win_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // No grant while reset is asserted, so nothing is offered upstream.
  assign xfer = rst_n && load && grant_vld;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ready_vec[i] = xfer && (grant == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr         <= '0;
    end else if (load) begin
      if (xfer) begin
        out_data_q  <= win_data;
        out_chan_q  <= grant;
        out_valid_q <= 1'b1;
        if (bus.mode) begin
          ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule
